// File: rtl/bus_arbiter.sv
// Registered shared-bus driver: one-hot select (ARB_MODE=0) or round-robin
// arbitration (ARB_MODE=1), with hold, conflict detection and grant output.
module bus_arbiter #(
    parameter int WIDTH       = 9,
    parameter int SRC_NUM     = 6,
    parameter int DEFAULT_SRC = SRC_NUM - 1,
    parameter int ARB_MODE    = 0,
    parameter int CNT_W       = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [SRC_NUM-1:0]       sel,
    input  logic [SRC_NUM*WIDTH-1:0] src_data,
    input  logic                     hold,
    output logic [WIDTH-1:0]         BusWires,
    output logic                     bus_valid,
    output logic [SRC_NUM-1:0]       grant,
    output logic                     conflict,
    output logic [CNT_W-1:0]         conflict_cnt
);

    localparam int IDX_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    logic [0:0]         state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   ptr, ptr_nxt;
    logic [IDX_W-1:0]   pick;
    logic               found;
    int                 base;
    logic [WIDTH-1:0]   bus_nxt;
    logic [SRC_NUM-1:0] grant_nxt;
    logic               valid_nxt;
    logic               conflict_nxt;

    function automatic logic [WIDTH-1:0] src_word(input logic [SRC_NUM*WIDTH-1:0] d,
                                                  input int idx);
        return d[idx*WIDTH +: WIDTH];
    endfunction

    function automatic int unsigned ones(input logic [SRC_NUM-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    function automatic int first_set(input logic [SRC_NUM-1:0] v);
        int idx;
        idx = 0;
        for (int i = SRC_NUM - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

    // First requester at or after base, wrapping around the source ring.
    function automatic void rr_pick(input logic [SRC_NUM-1:0] req, input int start,
                                    output logic hit, output logic [IDX_W-1:0] idx);
        int j;
        hit = 1'b0;
        idx = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            j = (start + k) % SRC_NUM;
            if (!hit && req[j]) begin
                hit = 1'b1;
                idx = IDX_W'(j);
            end
        end
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        ptr_nxt      = ptr;
        found        = 1'b0;
        pick         = '0;
        base         = 0;
        bus_nxt      = src_word(src_data, DEFAULT_SRC);
        grant_nxt    = '0;
        valid_nxt    = 1'b0;
        conflict_nxt = 1'b0;
        if (ARB_MODE == 0) begin
            if (ones(sel) == 1) begin
                bus_nxt   = src_word(src_data, first_set(sel));
                grant_nxt = sel;
                valid_nxt = 1'b1;
            end else if (ones(sel) > 1) begin
                conflict_nxt = 1'b1;
            end
        end else begin
            if (state == ST_OWNED && sel[owner]) begin
                bus_nxt   = src_word(src_data, int'(owner));
                grant_nxt = SRC_NUM'(1) << owner;
                valid_nxt = 1'b1;
            end else begin
                // A releasing owner moves the pointer past itself and hands over in the same cycle.
                if (state == ST_OWNED) begin
                    base    = (int'(owner) + 1) % SRC_NUM;
                    ptr_nxt = IDX_W'(base);
                end else begin
                    base = int'(ptr);
                end
                rr_pick(sel, base, found, pick);
                if (found) begin
                    state_nxt = ST_OWNED;
                    owner_nxt = pick;
                    bus_nxt   = src_word(src_data, int'(pick));
                    grant_nxt = SRC_NUM'(1) << pick;
                    valid_nxt = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
        end
    end

    // Output register stage
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state        <= ST_IDLE;
            owner        <= '0;
            ptr          <= '0;
            BusWires     <= '0;
            bus_valid    <= 1'b0;
            grant        <= '0;
            conflict     <= 1'b0;
            conflict_cnt <= '0;
        end else if (hold) begin
            conflict <= 1'b0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            ptr       <= ptr_nxt;
            BusWires  <= bus_nxt;
            bus_valid <= valid_nxt;
            grant     <= grant_nxt;
            conflict  <= conflict_nxt;
            if (conflict_nxt) conflict_cnt <= sat_inc(conflict_cnt);
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: select-mode, saturating-counter and round-robin instances
// share stimulus and are checked against a behavioural model.
module tb_bus_arbiter;
    localparam int W = 9;
    localparam int N = 6;

    logic           Clock, Reset, hold;
    logic [N-1:0]   sel;
    logic [N*W-1:0] src_data;
    logic [W-1:0]   words [N];

    logic [W-1:0] s_bus, t_bus, r_bus;
    logic         s_valid, t_valid, r_valid;
    logic         s_conf, t_conf, r_conf;
    logic [N-1:0] s_grant, t_grant, r_grant;
    logic [7:0]   s_cnt, r_cnt;
    logic [1:0]   t_cnt;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.WIDTH(W), .SRC_NUM(N), .ARB_MODE(0), .CNT_W(8)) u_sel (
        .Clock(Clock), .Reset(Reset), .sel(sel), .src_data(src_data), .hold(hold),
        .BusWires(s_bus), .bus_valid(s_valid), .grant(s_grant), .conflict(s_conf),
        .conflict_cnt(s_cnt));

    bus_arbiter #(.WIDTH(W), .SRC_NUM(N), .ARB_MODE(0), .CNT_W(2)) u_sat (
        .Clock(Clock), .Reset(Reset), .sel(sel), .src_data(src_data), .hold(hold),
        .BusWires(t_bus), .bus_valid(t_valid), .grant(t_grant), .conflict(t_conf),
        .conflict_cnt(t_cnt));

    bus_arbiter #(.WIDTH(W), .SRC_NUM(N), .ARB_MODE(1), .CNT_W(8)) u_rr (
        .Clock(Clock), .Reset(Reset), .sel(sel), .src_data(src_data), .hold(hold),
        .BusWires(r_bus), .bus_valid(r_valid), .grant(r_grant), .conflict(r_conf),
        .conflict_cnt(r_cnt));

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always_comb begin
        src_data = '0;
        for (int k = 0; k < N; k++) src_data[k*W +: W] = words[k];
    end

    // Behavioural model: owner is -1 when nobody holds the bus.
    logic [W-1:0] e_bus_s, e_bus_r, x_bus_s, x_bus_r;
    logic [N-1:0] e_grant_s, e_grant_r, x_grant_s, x_grant_r;
    logic         e_valid_s, e_valid_r, x_valid_s, x_valid_r, e_conf, x_conf;
    int           e_cnt, e_cnt_sat, m_owner, m_ptr, x_owner, x_ptr;

    always_comb begin
        x_bus_s   = words[N-1];
        x_grant_s = '0;
        x_valid_s = 1'b0;
        x_conf    = 1'b0;
        x_bus_r   = words[N-1];
        x_grant_r = '0;
        x_valid_r = 1'b0;
        x_owner   = -1;
        x_ptr     = m_ptr;
        if ($countones(sel) == 1) begin
            for (int k = 0; k < N; k++) if (sel[k]) x_bus_s = words[k];
            x_grant_s = sel;
            x_valid_s = 1'b1;
        end else if ($countones(sel) > 1) begin
            x_conf = 1'b1;
        end
        if (m_owner >= 0 && sel[m_owner]) begin
            x_owner = m_owner;
        end else begin
            if (m_owner >= 0) x_ptr = (m_owner + 1) % N;
            for (int k = 0; k < N; k++) if (x_owner < 0 && sel[(x_ptr + k) % N]) x_owner = (x_ptr + k) % N;
        end
        if (x_owner >= 0) begin
            x_bus_r   = words[x_owner];
            x_grant_r = 6'b000001 << x_owner;
            x_valid_r = 1'b1;
        end
    end

    always @(posedge Clock) begin
        if (Reset) begin
            e_bus_s <= '0; e_grant_s <= '0; e_valid_s <= 1'b0; e_conf <= 1'b0;
            e_cnt <= 0; e_cnt_sat <= 0;
            e_bus_r <= '0; e_grant_r <= '0; e_valid_r <= 1'b0;
            m_owner <= -1; m_ptr <= 0;
        end else if (hold) begin
            e_conf <= 1'b0;
        end else begin
            e_bus_s <= x_bus_s; e_grant_s <= x_grant_s; e_valid_s <= x_valid_s; e_conf <= x_conf;
            if (x_conf && e_cnt < 255) e_cnt <= e_cnt + 1;
            if (x_conf && e_cnt_sat < 3) e_cnt_sat <= e_cnt_sat + 1;
            e_bus_r <= x_bus_r; e_grant_r <= x_grant_r; e_valid_r <= x_valid_r;
            m_owner <= x_owner; m_ptr <= x_ptr;
        end
    end

    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic new_words();
        for (int k = 0; k < N; k++) words[k] = 9'($urandom);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        sel = 6'($urandom);
        new_words();
        tick();
        tick();
        checks++;
        if ({s_bus, s_valid, s_grant, s_conf, s_cnt} !== 25'h0) begin
            errors++;
            $display("FAIL reset_sel got %h want 0", {s_bus, s_valid, s_grant, s_conf, s_cnt});
        end
        checks++;
        if ({r_bus, r_valid, r_grant, r_conf, r_cnt, t_cnt} !== 27'h0) begin
            errors++;
            $display("FAIL reset_rr got %h want 0", {r_bus, r_valid, r_grant, r_conf, r_cnt, t_cnt});
        end
        Reset = 1'b0;
    endtask

    task automatic test_select_onehot();
        int k;
        sel = 6'b000001;
        words[0] = 9'h1A5;
        tick();
        checks++;
        if (s_bus !== 9'h1A5 || s_grant !== 6'b000001 || s_valid !== 1'b1) begin
            errors++;
            $display("FAIL onehot_src0 got bus=%h grant=%b valid=%b want 1a5 000001 1", s_bus, s_grant, s_valid);
        end
        for (int i = 0; i < 20; i++) begin
            k = $urandom_range(0, N - 1);
            sel = 6'b000001 << k;
            new_words();
            tick();
            checks++;
            if (s_bus !== words[k] || s_grant !== (6'b000001 << k) || s_valid !== 1'b1 || s_conf !== 1'b0) begin
                errors++;
                $display("FAIL onehot_rand src=%0d got bus=%h grant=%b valid=%b conf=%b want %h", k, s_bus, s_grant, s_valid, s_conf, words[k]);
            end
        end
    endtask

    task automatic test_conflict();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sel = 6'b000011;
        words[N-1] = 9'h055;
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (s_conf !== 1'b1 || s_bus !== 9'h055 || s_valid !== 1'b0 || s_grant !== 6'b0) begin
                errors++;
                $display("FAIL conflict_pulse cyc=%0d got conf=%b bus=%h valid=%b grant=%b want 1 055 0 0", i, s_conf, s_bus, s_valid, s_grant);
            end
            if (i == 3) begin
                checks++;
                if (s_cnt !== 8'd3) begin
                    errors++;
                    $display("FAIL conflict_cnt3 got %0d want 3", s_cnt);
                end
            end
        end
        checks++;
        if (t_cnt !== 2'd3 || s_cnt !== 8'd5) begin
            errors++;
            $display("FAIL conflict_sat got sat=%0d full=%0d want 3 5", t_cnt, s_cnt);
        end
        sel = 6'b000000;
        new_words();
        tick();
        checks++;
        if (s_conf !== 1'b0 || s_bus !== words[N-1] || s_valid !== 1'b0 || s_grant !== 6'b0 || s_cnt !== 8'd5) begin
            errors++;
            $display("FAIL default_src got conf=%b bus=%h valid=%b grant=%b cnt=%0d want 0 %h 0 0 5", s_conf, s_bus, s_valid, s_grant, s_cnt, words[N-1]);
        end
    endtask

    task automatic test_round_robin();
        Reset = 1'b1;
        sel = '0;
        tick();
        Reset = 1'b0;
        sel = 6'b100100;
        new_words();
        tick();
        checks++;
        if (r_grant !== 6'b000100 || r_bus !== words[2] || r_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_first got grant=%b bus=%h want 000100 %h", r_grant, r_bus, words[2]);
        end
        words[2] = 9'($urandom);
        tick();
        checks++;
        if (r_grant !== 6'b000100 || r_bus !== words[2]) begin
            errors++;
            $display("FAIL rr_track got grant=%b bus=%h want 000100 %h", r_grant, r_bus, words[2]);
        end
        sel = 6'b100000;
        tick();
        checks++;
        if (r_grant !== 6'b100000 || r_bus !== words[5] || r_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_handover got grant=%b bus=%h want 100000 %h", r_grant, r_bus, words[5]);
        end
        sel = 6'b000001;
        tick();
        checks++;
        if (r_grant !== 6'b000001 || r_bus !== words[0]) begin
            errors++;
            $display("FAIL rr_wrap got grant=%b bus=%h want 000001 %h", r_grant, r_bus, words[0]);
        end
        sel = 6'b000000;
        tick();
        checks++;
        if (r_grant !== 6'b0 || r_valid !== 1'b0 || r_bus !== words[5] || r_conf !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle got grant=%b valid=%b bus=%h conf=%b want 0 0 %h 0", r_grant, r_valid, r_bus, r_conf, words[5]);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] sb, rb;
        logic [N-1:0] sg, rg;
        logic [7:0]   sc;
        sel = 6'b000011;
        new_words();
        tick();
        sb = s_bus; sg = s_grant; sc = s_cnt;
        rb = r_bus; rg = r_grant;
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sel = 6'($urandom);
            new_words();
            tick();
            checks++;
            if (s_bus !== sb || s_grant !== sg || s_cnt !== sc || s_conf !== 1'b0 || r_bus !== rb || r_grant !== rg) begin
                errors++;
                $display("FAIL hold_freeze cyc=%0d got s=%h/%b/%0d/%b r=%h/%b want %h/%b/%0d/0 %h/%b", i, s_bus, s_grant, s_cnt, s_conf, r_bus, r_grant, sb, sg, sc, rb, rg);
            end
        end
        hold = 1'b0;
        sel = 6'b010000;
        words[4] = 9'($urandom);
        tick();
        checks++;
        if (s_grant !== 6'b010000 || s_bus !== words[4] || r_grant !== 6'b010000 || r_bus !== words[4]) begin
            errors++;
            $display("FAIL hold_release got s=%b/%h r=%b/%h want 010000/%h", s_grant, s_bus, r_grant, r_bus, words[4]);
        end
    endtask

    task automatic test_reset_mid_own();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        sel = 6'b001000;
        new_words();
        tick();
        checks++;
        if (r_grant !== 6'b001000) begin
            errors++;
            $display("FAIL midreset_own got grant=%b want 001000", r_grant);
        end
        Reset = 1'b1;
        sel = 6'b111111;
        tick();
        checks++;
        if ({r_bus, r_valid, r_grant, s_bus, s_valid, s_grant, s_conf, s_cnt} !== 41'h0) begin
            errors++;
            $display("FAIL midreset_zero got r=%h/%b/%b s=%h/%b/%b/%b/%0d want 0", r_bus, r_valid, r_grant, s_bus, s_valid, s_grant, s_conf, s_cnt);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (r_grant !== 6'b000001 || r_bus !== words[0]) begin
            errors++;
            $display("FAIL midreset_ptr0 got grant=%b bus=%h want 000001 %h", r_grant, r_bus, words[0]);
        end
    endtask

    task automatic test_random_mixed();
        for (int i = 0; i < 300; i++) begin
            Reset = ($urandom_range(0, 99) < 3);
            hold  = ($urandom_range(0, 99) < 15);
            for (int k = 0; k < N; k++) sel[k] = ($urandom_range(0, 99) < 35);
            new_words();
            tick();
            checks++;
            if ({s_bus, s_valid, s_grant, s_conf, s_cnt} !== {e_bus_s, e_valid_s, e_grant_s, e_conf, 8'(e_cnt)}) begin
                errors++;
                $display("FAIL rand_sel cyc=%0d got %h want %h", i, {s_bus, s_valid, s_grant, s_conf, s_cnt}, {e_bus_s, e_valid_s, e_grant_s, e_conf, 8'(e_cnt)});
            end
            checks++;
            if ({t_bus, t_valid, t_grant, t_conf, t_cnt} !== {e_bus_s, e_valid_s, e_grant_s, e_conf, 2'(e_cnt_sat)}) begin
                errors++;
                $display("FAIL rand_sat cyc=%0d got %h want %h", i, {t_bus, t_valid, t_grant, t_conf, t_cnt}, {e_bus_s, e_valid_s, e_grant_s, e_conf, 2'(e_cnt_sat)});
            end
            checks++;
            if ({r_bus, r_valid, r_grant, r_conf, r_cnt} !== {e_bus_r, e_valid_r, e_grant_r, 1'b0, 8'h00}) begin
                errors++;
                $display("FAIL rand_rr cyc=%0d got %h want %h", i, {r_bus, r_valid, r_grant, r_conf, r_cnt}, {e_bus_r, e_valid_r, e_grant_r, 1'b0, 8'h00});
            end
        end
        Reset = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        hold  = 1'b0;
        sel   = '0;
        for (int k = 0; k < N; k++) words[k] = '0;
        test_reset();
        test_select_onehot();
        test_conflict();
        test_round_robin();
        test_hold();
        test_reset_mid_own();
        test_random_mixed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
